// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, LSB-first frame, optional parity, error pulses.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit instead of a single sample.
module uart_rx #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   output logic [DATA_WIDTH-1:0]     P_DATA,
   output logic                      data_valid,
   output logic                      par_err,
   output logic                      stp_err,
   output logic                      busy
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t r_state, w_state_next;

   logic [PRESCALE_WIDTH-1:0] r_prescale, r_edge_cnt, w_half;
   logic [BW-1:0]             r_bit_cnt;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic                      r_par_en, r_par_typ, r_par_bad;
   logic                      w_wrap, w_decide, w_bit;

   assign w_half = r_prescale >> 1;
   assign w_wrap = (r_edge_cnt == r_prescale - ONE);
   assign busy   = (r_state != IDLE);

`ifdef UART_RX_MAJORITY_EN
   logic r_s0, r_s1;

   // The two earlier votes are held; the third is the live line at the decision cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_s0 <= 1'b1;
         r_s1 <= 1'b1;
      end else begin
         if (r_edge_cnt == w_half - ONE) r_s0 <= RX_IN;
         if (r_edge_cnt == w_half)       r_s1 <= RX_IN;
      end
   end

   assign w_decide = (r_edge_cnt == w_half + ONE);
   assign w_bit    = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
`else
   assign w_decide = (r_edge_cnt == w_half);
   assign w_bit    = RX_IN;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (!RX_IN) w_state_next = START;
         START: begin
            if (w_decide && w_bit) w_state_next = IDLE;
            else if (w_wrap)       w_state_next = DATA;
         end
         DATA:    if (w_wrap && r_bit_cnt == LAST_BIT)
                     w_state_next = r_par_en ? PARITY : STOP;
         PARITY:  if (w_wrap) w_state_next = STOP;
         STOP:    if (w_decide) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Edge counter: the IDLE cycle that sees the start edge already counts as edge 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                          r_edge_cnt <= '0;
      else if (w_state_next == IDLE)    r_edge_cnt <= '0;
      else if (r_state == IDLE)         r_edge_cnt <= ONE;
      else if (w_wrap)                  r_edge_cnt <= '0;
      else                              r_edge_cnt <= r_edge_cnt + ONE;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_prescale <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_par_bad  <= 1'b0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         case (r_state)
            IDLE: begin
               r_prescale <= prescale;
               r_par_en   <= PAR_EN;
               r_par_typ  <= PAR_TYP;
               r_par_bad  <= 1'b0;
               r_bit_cnt  <= '0;
            end
            DATA: begin
               if (w_decide) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
               if (w_wrap)   r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            PARITY: begin
               if (w_decide) r_par_bad <= w_bit ^ (^r_shift) ^ r_par_typ;
            end
            STOP: begin
               if (w_decide) begin
                  if (!r_par_bad && w_bit) begin
                     P_DATA     <= r_shift;
                     data_valid <= 1'b1;
                  end
                  par_err <= r_par_bad;
                  stp_err <= !w_bit;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the receive half of the system UART next to the existing transmitter. It detects a start bit on `RX_IN`, samples each bit at mid-bit, and reassembles an 8-bit LSB-first frame with optional parity. It presents the byte on `P_DATA` with a one-cycle `data_valid` pulse and flags parity and stop-bit errors. `CLK` is the oversampled UART clock, running at `prescale` × baud.

## Interface
Parameters:
- `DATA_WIDTH`, default 8, payload bits per frame.
- `PRESCALE_WIDTH`, default 6, width of the `prescale` input.

Ports:
- `CLK`, in, 1, receiver clock (oversampled, `prescale` × baud).
- `RST`, in, 1, reset: asynchronous, active-high.
- `RX_IN`, in, 1, serial line. Already synchronised to `CLK` upstream; idle high.
- `prescale`, in, PRESCALE_WIDTH, oversampling ratio. Legal values: 8, 16, 32.
- `PAR_EN`, in, 1, 1 = parity bit present between data and stop.
- `PAR_TYP`, in, 1, 0 = even parity, 1 = odd parity.
- `P_DATA`, out, DATA_WIDTH, received byte. Held until the next good frame.
- `data_valid`, out, 1, one-cycle pulse marking a good frame.
- `par_err`, out, 1, one-cycle pulse when the parity check fails.
- `stp_err`, out, 1, one-cycle pulse when the stop bit is sampled low.
- `busy`, out, 1, high whenever the FSM is not IDLE.

## Operation
- **Reset values:** all outputs 0, FSM in IDLE, counters 0.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Counters:**
  - `edge_cnt` runs 0..prescale-1 within each bit and wraps at prescale-1.
  - `bit_cnt` runs 0..DATA_WIDTH-1 in DATA.
- **IDLE:**
  - When `RX_IN`=0, go to START. That cycle counts as `edge_cnt`=0 of the start bit.
  - `prescale`, `PAR_EN` and `PAR_TYP` are latched in this cycle. Changes to them mid-frame are ignored.
- **Sample point:** `edge_cnt` = prescale/2 (see Configuration for the majority-vote variant). The sampled value is the bit value.
- **START:**
  - Sampled 1: glitch. Return to IDLE at the sample point. No error, no pulse.
  - Sampled 0: go to DATA at `edge_cnt` wrap.
- **DATA:**
  - Each sampled bit shifts into the shift register, LSB first.
  - After bit DATA_WIDTH-1 wraps, go to PARITY if the latched `PAR_EN`=1, else go to STOP.
- **PARITY:**
  - Expected bit = XOR of the 8 data bits, inverted when `PAR_TYP`=1.
  - A mismatch is recorded internally. Go to STOP at wrap.
- **STOP:** at the sample point, evaluate the stop bit and return to IDLE immediately, at mid stop bit. This gives half a bit of tolerance for baud mismatch and allows back-to-back frames.
- **Result, registered in the cycle after the stop sample point:**
  - No error: `P_DATA` is updated and `data_valid`=1 for one cycle.
  - Parity error, stop error, or both: the corresponding error pulse(s) fire, `data_valid` stays 0 and `P_DATA` is unchanged.
- **Priority:** a framing and a parity error in the same frame raise both pulses in the same cycle.
- **Reset mid-frame:** the frame is abandoned. No pulses, outputs return to reset values.

## Timing
- Let T = the cycle `RX_IN` is first seen low in IDLE. The sample point of bit k (start = 0) is T + k·prescale + prescale/2.
- 8N1, prescale=8: stop sample at T+76; `data_valid` at T+77.
- 8E1, prescale=16: stop sample at T+168; pulse at T+169.
- `busy` rises at T+1 and falls in the cycle after the stop sample.
- The next start edge is accepted from the first IDLE cycle onward.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** each bit is sampled at `edge_cnt` = prescale/2-1, prescale/2 and prescale/2+1. The bit value is the 2-of-3 majority, decided at prescale/2+1. All sample points, error pulses and `data_valid` move one cycle later.
- **Undefined:** single sample at prescale/2, with the timing exactly as stated above.

## Test plan
- **Good 8N1 frame:** prescale=8, PAR_EN=0, send 0xA5 → `P_DATA`=0xA5 with a single `data_valid` pulse at T+77 (T+78 with the macro); no error pulses.
- **Even parity:** prescale=16, PAR_TYP=0, send 0x3C with parity bit 0 → valid. Same frame with parity bit 1 → `par_err` pulse only, `P_DATA` keeps its previous value.
- **Framing error:** odd parity, prescale=32, stop bit driven low → `stp_err` pulse, no `data_valid`.
- **Start glitch:** `RX_IN` low for 2 cycles at prescale=8 → FSM back to IDLE, `busy` low, no pulses. With the macro, also check that a 1-cycle spike at the sample point is rejected.
- **Back-to-back:** frames 0x01, 0xFF, 0x80 with no idle gap → three `data_valid` pulses with the correct bytes.
- **Reset mid-frame:** assert `RST` during DATA bit 4 → all outputs 0 immediately; a following clean 0x55 frame is received correctly.
